// File: rtl/fb_triple_buf_ctrl.sv
// fb_triple_buf_ctrl
//
// Triple-buffer scheduler for the camera-to-VGA frame store. Three frame
// buffers rotate between three roles: the one the camera is writing
// (wr_buf), the most recent completed frame waiting for the display
// (ready_buf, internal), and the one the display is scanning (rd_buf).
// The display only switches buffers at the start of vertical blank, so it
// never shows a partially written frame. The block also produces the
// camera-side pixel write address and write enable.
//
// Ports:
//   clk               system clock, rising edge
//   reset             asynchronous, active-high reset
//   cam_frame_start   one-cycle pulse at the start of a camera frame
//   cam_pix_we        one-cycle strobe per captured pixel
//   cam_frame_done    one-cycle pulse at the end of a camera frame
//   disp_frame_start  one-cycle pulse at the start of VGA vertical blank
//   wr_buf            buffer index the camera writes
//   wr_addr           pixel offset within wr_buf
//   wr_en             memory write enable (combinational, same cycle as strobe)
//   rd_buf            buffer index the display reads
//   frame_ready       the ready slot holds a completed, unread frame
//   wr_overflow       too many pixels seen in the current frame (sticky)
//   drop_cnt          completed frames overwritten before being displayed
//
// Build option:
//   FB_DROP_CNT_EN    when defined, drop_cnt counts drop events and saturates
//                     at 16'hFFFF; otherwise drop_cnt is tied to 0.

module fb_triple_buf_ctrl #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = $clog2(H_RES*V_RES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cam_frame_start,
  input  logic              cam_pix_we,
  input  logic              cam_frame_done,
  input  logic              disp_frame_start,
  output logic [1:0]        wr_buf,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic [1:0]        rd_buf,
  output logic              frame_ready,
  output logic              wr_overflow,
  output logic [15:0]       drop_cnt
);

  localparam int                FRAME_PIX = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] FULL_ADDR = ADDR_W'(FRAME_PIX);

  // Which role rotation the slot registers perform this cycle.
  typedef enum logic [1:0] {
    UPD_HOLD,     // nothing to do (includes display repeat with no new frame)
    UPD_PUBLISH,  // completed frame moves into the ready slot
    UPD_TAKE,     // display picks up the ready frame
    UPD_ROTATE    // display picks up the frame completing this very cycle
  } upd_e;

  upd_e        upd;
  logic [1:0]  ready_buf;
  logic [1:0]  wr_buf_nx, ready_buf_nx, rd_buf_nx;
  logic        frame_ready_nx;
  logic        addr_full;
  logic        valid_done;

  assign addr_full  = (wr_addr == FULL_ADDR);

  // Only an exactly-sized frame is published; short or long frames leave the
  // slots alone so the camera simply overwrites the same buffer next time.
  assign valid_done = cam_frame_done & addr_full & ~wr_overflow;

  // Gated by reset so nothing reaches memory while the block is held in reset.
  assign wr_en = cam_pix_we & ~cam_frame_start & (wr_addr < FULL_ADDR) & ~reset;

  always_comb begin
    upd            = UPD_HOLD;
    wr_buf_nx      = wr_buf;
    ready_buf_nx   = ready_buf;
    rd_buf_nx      = rd_buf;
    frame_ready_nx = frame_ready;

    if (valid_done && disp_frame_start)      upd = UPD_ROTATE;
    else if (valid_done)                     upd = UPD_PUBLISH;
    else if (disp_frame_start && frame_ready) upd = UPD_TAKE;

    case (upd)
      UPD_PUBLISH: begin
        wr_buf_nx      = ready_buf;
        ready_buf_nx   = wr_buf;
        frame_ready_nx = 1'b1;
      end
      UPD_TAKE: begin
        rd_buf_nx      = ready_buf;
        ready_buf_nx   = rd_buf;
        frame_ready_nx = 1'b0;
      end
      UPD_ROTATE: begin
        // The just-finished frame goes straight to the display; the stale
        // ready frame (if any) is recycled as the next write target.
        rd_buf_nx      = wr_buf;
        wr_buf_nx      = ready_buf;
        ready_buf_nx   = rd_buf;
        frame_ready_nx = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_buf      <= 2'd0;
      ready_buf   <= 2'd1;
      rd_buf      <= 2'd2;
      frame_ready <= 1'b0;
    end else begin
      wr_buf      <= wr_buf_nx;
      ready_buf   <= ready_buf_nx;
      rd_buf      <= rd_buf_nx;
      frame_ready <= frame_ready_nx;
    end
  end

  // A frame start in the same cycle as a valid done: the slot update above
  // already retargets wr_buf, and the address restarts at 0 for the new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr     <= '0;
      wr_overflow <= 1'b0;
    end else if (cam_frame_start) begin
      wr_addr     <= '0;
      wr_overflow <= 1'b0;
    end else begin
      if (wr_en)                  wr_addr     <= wr_addr + ADDR_W'(1);
      if (cam_pix_we && addr_full) wr_overflow <= 1'b1;
    end
  end

`ifdef FB_DROP_CNT_EN
  // A drop is a completed frame being replaced while the previous completed
  // frame was still unread.
  logic drop_evt;
  assign drop_evt = valid_done & frame_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      drop_cnt <= '0;
    else if (drop_evt && (drop_cnt != 16'hFFFF))
      drop_cnt <= drop_cnt + 16'd1;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule
